serial_add_sub: RTL

//  Parametrised bit-serial N-bit adder/subtractor built around one 1-bit full adder/subtractor cell.
//  - Captures two operands on a start handshake and processes one bit per clock, LSB first.
//  - Presents a registered result with carry, signed overflow and zero flags.
//  - Optionally saturates the result on signed overflow.
//  - Low-area arithmetic engine for datapaths that can tolerate WIDTH+1 cycles of latency.

---
 rtl/serial_add_sub_pkg.sv | 13 +
 rtl/serial_add_sub_fas_bit.sv | 14 +
 rtl/serial_add_sub.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_add_sub_fas_bit.sv
// Combinational 1-bit full adder cell; subtraction is handled upstream
// by feeding it ~b with a carry-in of 1.
module fas_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first,
// registered result with carry, signed overflow and zero flags.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_ns,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic             sign_a_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  logic             accept_s;
  logic             last_s;
  logic             sum_bit_s;
  logic             cout_bit_s;
  logic [WIDTH-1:0] sum_full_s;
  logic             ovf_s;
  logic [WIDTH-1:0] s_final_s;

  fas_bit u_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (sum_bit_s),
    .cout (cout_bit_s)
  );

  // Next-state decode plus final-bit result assembly.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s    = start;
        state_nxt_s = start ? RUN : IDLE;
      end
      RUN: begin
        last_s      = (cnt_r == LAST);
        state_nxt_s = (cnt_r == LAST) ? DONE : RUN;
      end
      DONE: begin
        accept_s    = start;
        state_nxt_s = start ? RUN : IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // On the last bit-cycle carry_r is the carry into the MSB.
    sum_full_s = {sum_bit_s, acc_r[WIDTH-1:1]};
    ovf_s      = carry_r ^ cout_bit_s;
    if (SAT && ovf_s) begin
      s_final_s = sign_a_r ? SAT_MIN : SAT_MAX;
    end else begin
      s_final_s = sum_full_s;
    end
  end

  // State register and status outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand load, serial datapath and result/flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      sign_a_r <= 1'b0;
      s_r      <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r    <= {CW{1'b0}};
      a_sh_r   <= a;
      b_sh_r   <= (a_ns == ADD) ? b : ~b;
      carry_r  <= (a_ns == SUB);
      sign_a_r <= a[WIDTH-1];
    end else if (state_r == RUN) begin
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      acc_r   <= sum_full_s;
      carry_r <= cout_bit_s;
      if (last_s) begin
        s_r    <= s_final_s;
        cout_r <= cout_bit_s;
        ovf_r  <= ovf_s;
        zero_r <= (s_final_s == {WIDTH{1'b0}});
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
  assign zero = zero_r;

endmodule
